// File: rtl/fg_multichannel_wavegen_if.sv
// fg_multichannel_wavegen_if: configuration/commit bus between register interface and waveform generator
interface fg_multichannel_wavegen_if #(
  parameter int CH_W = 1,
  parameter int CFG_W = 16
);
  logic we;
  logic [CH_W-1:0] ch;
  logic [2:0] addr;
  logic [CFG_W-1:0] data;
  logic commit;
  logic pending;
  modport master (output we, ch, addr, data, commit, input pending);
  modport slave (input we, ch, addr, data, commit, output pending);
endinterface

// File: rtl/fg_multichannel_wavegen.sv
// fg_multichannel_wavegen: multichannel phase-accumulator waveform generator with shadowed, tick-aligned commits
module fg_multichannel_wavegen #(
  parameter int NUM_CH = 2,
  parameter int BITWIDTH = 8,
  parameter int PHASE_W = 12,
  parameter int PSC_W = 9,
  parameter int BURST_W = 8,
  parameter int CH_W = 1,
  parameter int CFG_W = 16
) (
  input logic clk_i,
  input logic rst_i,
  input logic enable_i,
  fg_multichannel_wavegen_if.slave cfg,
  output logic [NUM_CH*BITWIDTH-1:0] out_o,
  output logic out_valid_o,
  output logic [NUM_CH-1:0] done_o
);
  localparam int B = BITWIDTH;
  localparam int W = 2 * BITWIDTH + 2;
  localparam logic [B-1:0] LO = {1'b1, {(B-1){1'b0}}};
  localparam logic [B-1:0] HI = ~LO;
  localparam logic signed [W-1:0] YMAX = W'(2 ** (B - 1) - 1);
  localparam logic signed [W-1:0] YMIN = ~YMAX;
  logic [PSC_W-1:0] psc_s, psc_a, cnt;
  logic tick, apply, tick_d, wr;
  logic unused_ok;
  assign unused_ok = ^cfg.data;
  assign tick = enable_i && cnt == psc_a;
  assign apply = cfg.pending && (tick || !enable_i);
  assign wr = cfg.we && cfg.addr != 3'd7;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      psc_s <= '0;
      psc_a <= '0;
      cnt <= '0;
      tick_d <= 1'b0;
      out_valid_o <= 1'b0;
      cfg.pending <= 1'b0;
    end else begin
      psc_s <= wr && cfg.addr == 3'd6 ? cfg.data[PSC_W-1:0] : psc_s;
      psc_a <= apply ? psc_s : psc_a;
      cnt <= apply || tick ? '0 : enable_i ? cnt + PSC_W'(1) : cnt;
      tick_d <= apply ? 1'b0 : enable_i ? tick : tick_d;
      out_valid_o <= enable_i && tick_d;
      cfg.pending <= !apply && (cfg.pending || cfg.commit);
    end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [PHASE_W-1:0] step_s, step_a, duty_s, duty_a, phase;
    logic [B-1:0] amp_s, amp_a, off_s, off_a, u, v, s, sat, res, out_q;
    logic [1:0] mode_s, mode_a;
    logic radix_s, radix_a, done, hit;
    logic [BURST_W-1:0] burst_s, burst_a, pcnt;
    logic [PHASE_W:0] sum;
    logic signed [W-1:0] prod, y;
    assign hit = wr && cfg.addr != 3'd6 && cfg.ch == CH_W'(c);
    assign sum = {1'b0, phase} + {1'b0, step_a};
    always_comb begin
      u = phase[PHASE_W-1 -: B];
      v = phase[PHASE_W-1] ? ~phase[PHASE_W-2 -: B] : phase[PHASE_W-2 -: B];
      s = mode_a == 2'd0 ? u ^ LO : mode_a == 2'd1 ? v ^ LO : mode_a == 2'd2 ? (phase < duty_a ? HI : LO) : HI;
      prod = W'($signed(s)) * W'($signed({1'b0, amp_a}));
      y = done ? W'($signed(off_a)) : (prod >>> (B - 1)) + W'($signed(off_a));
      sat = y > YMAX ? HI : y < YMIN ? LO : y[B-1:0];
      res = {sat[B-1] ^ radix_a, sat[B-2:0]};
    end
    always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
        step_s <= '0;
        duty_s <= '0;
        amp_s <= '0;
        off_s <= '0;
        mode_s <= '0;
        radix_s <= 1'b0;
        burst_s <= '0;
        step_a <= '0;
        duty_a <= '0;
        amp_a <= '0;
        off_a <= '0;
        mode_a <= '0;
        radix_a <= 1'b0;
        burst_a <= '0;
        phase <= '0;
        pcnt <= '0;
        done <= 1'b0;
        out_q <= '0;
      end else begin
        step_s <= hit && cfg.addr == 3'd0 ? cfg.data[PHASE_W-1:0] : step_s;
        duty_s <= hit && cfg.addr == 3'd1 ? cfg.data[PHASE_W-1:0] : duty_s;
        amp_s <= hit && cfg.addr == 3'd2 ? cfg.data[B-1:0] : amp_s;
        off_s <= hit && cfg.addr == 3'd3 ? cfg.data[B-1:0] : off_s;
        mode_s <= hit && cfg.addr == 3'd4 ? cfg.data[1:0] : mode_s;
        radix_s <= hit && cfg.addr == 3'd4 ? cfg.data[2] : radix_s;
        burst_s <= hit && cfg.addr == 3'd5 ? cfg.data[BURST_W-1:0] : burst_s;
        if (apply) begin
          step_a <= step_s;
          duty_a <= duty_s;
          amp_a <= amp_s;
          off_a <= off_s;
          mode_a <= mode_s;
          radix_a <= radix_s;
          burst_a <= burst_s;
          phase <= '0;
          pcnt <= '0;
          done <= 1'b0;
        end else if (tick && !done) begin
          if (sum[PHASE_W] && burst_a != '0 && pcnt + BURST_W'(1) == burst_a) begin
            done <= 1'b1;
            phase <= '0;
          end else begin
            phase <= sum[PHASE_W-1:0];
            pcnt <= pcnt + BURST_W'(sum[PHASE_W]);
          end
        end
        if (enable_i && tick_d) out_q <= res;
      end
    assign out_o[c*B +: B] = out_q;
    assign done_o[c] = done;
  end
endmodule

// File: tb/tb_fg_multichannel_wavegen.sv
// tb_fg_multichannel_wavegen: directed self-checking bench for fg_multichannel_wavegen
module tb_fg_multichannel_wavegen;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic enable_i = 1'b1;
  logic [15:0] out_o;
  logic out_valid_o;
  logic [1:0] done_o;
  int vectors = 0;
  int errors = 0;
  int n, nv;
  fg_multichannel_wavegen_if #(.CH_W(1), .CFG_W(16)) cfg ();
  fg_multichannel_wavegen dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .enable_i(enable_i),
    .cfg(cfg),
    .out_o(out_o),
    .out_valid_o(out_valid_o),
    .done_o(done_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic wr(input int ch, input int addr, input int data);
    cfg.we = 1'b1;
    cfg.ch = ch[0:0];
    cfg.addr = addr[2:0];
    cfg.data = data[15:0];
    cycle();
    cfg.we = 1'b0;
  endtask
  task automatic commit();
    cfg.commit = 1'b1;
    cycle();
    cfg.commit = 1'b0;
  endtask
  task automatic wait_valid(output int cycles);
    cycles = 0;
    do begin
      cycle();
      cycles++;
    end while (!out_valid_o && cycles < 50);
    if (!out_valid_o) chk("valid_timeout", 0, 1);
  endtask
  function automatic int o(input int c);
    logic [7:0] t;
    t = out_o[c*8 +: 8];
    return int'($signed(t));
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    cfg.we = 1'b0;
    cfg.ch = '0;
    cfg.addr = '0;
    cfg.data = '0;
    cfg.commit = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_out", int'(out_o), 0);
    chk("rst_valid", int'(out_valid_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_pending", int'(cfg.pending), 0);
    rst_i = 1'b0;
    wr(0, 0, 512);
    wr(0, 2, 128);
    commit();
    chk("t1_pending_set", int'(cfg.pending), 1);
    cycle();
    chk("t1_pending_clr", int'(cfg.pending), 0);
    cycle();
    chk("t1_commit_no_strobe", int'(out_valid_o), 0);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t1_valid", int'(out_valid_o), 1);
      chk("t1_saw", o(0), -96 + 32 * k);
    end
    chk("t1_ch1_idle", o(1), 0);
    wr(0, 4, 2);
    wr(0, 1, 2048);
    wr(0, 0, 1024);
    wr(0, 2, 255);
    wr(0, 3, 100);
    commit();
    repeat (3) cycle();
    chk("t2_sq_high", o(0), 127);
    cycle();
    chk("t2_sq_low", o(0), -128);
    cycle();
    chk("t2_sq_low2", o(0), -128);
    cycle();
    chk("t2_sq_high2", o(0), 127);
    wr(0, 0, 2048);
    wr(0, 5, 3);
    wr(0, 3, 16'hFFFB);
    wr(1, 0, 512);
    wr(1, 2, 128);
    commit();
    repeat (3) cycle();
    chk("t3_ch0_low", o(0), -128);
    chk("t3_ch1_saw", o(1), -96);
    repeat (3) cycle();
    chk("t3_done_early", int'(done_o), 0);
    cycle();
    chk("t3_done", int'(done_o), 1);
    cycle();
    chk("t3_ch0_offset", o(0), -5);
    chk("t3_ch1_run", o(1), 64);
    cycle();
    chk("t3_ch1_run2", o(1), 96);
    chk("t3_ch0_hold", o(0), -5);
    chk("t3_done_hold", int'(done_o), 1);
    wr(0, 4, 0);
    wr(0, 0, 512);
    wr(0, 2, 128);
    wr(0, 3, 0);
    wr(0, 5, 0);
    wr(0, 6, 4);
    commit();
    repeat (2) cycle();
    wait_valid(n);
    chk("t4_first_gap", n, 5);
    chk("t4_first", o(0), -96);
    chk("t4_done_clr", int'(done_o), 0);
    wait_valid(n);
    chk("t4_period", n, 5);
    chk("t4_second", o(0), -64);
    enable_i = 1'b0;
    wr(0, 4, 4);
    nv = int'(out_valid_o);
    for (int k = 0; k < 19; k++) begin
      cycle();
      nv += int'(out_valid_o);
    end
    chk("t4_frozen_strobes", nv, 0);
    chk("t4_frozen_out", o(0), -64);
    enable_i = 1'b1;
    wait_valid(n);
    chk("t4_resume_gap", n, 5);
    chk("t4_resume", o(0), -32);
    cfg.we = 1'b1;
    cfg.ch = 1'b0;
    cfg.addr = 3'd0;
    cfg.data = 16'd1024;
    cfg.commit = 1'b1;
    cycle();
    cfg.we = 1'b0;
    cfg.commit = 1'b0;
    chk("t5_pending1", int'(cfg.pending), 1);
    cycle();
    chk("t5_pending2", int'(cfg.pending), 1);
    cycle();
    chk("t5_pending3", int'(cfg.pending), 1);
    cycle();
    chk("t5_pending_clr", int'(cfg.pending), 0);
    wait_valid(n);
    chk("t5_gap", n, 6);
    chk("t5_radix_neg", int'(out_o[7:0]), 64);
    wait_valid(n);
    chk("t5_period", n, 5);
    chk("t5_radix_zero", int'(out_o[7:0]), 128);
    wr(1, 5, 1);
    wr(1, 0, 2048);
    commit();
    repeat (25) cycle();
    chk("t6_pre_done", int'(done_o), 2);
    commit();
    chk("t6_pre_pending", int'(cfg.pending), 1);
    #3;
    rst_i = 1'b1;
    #1;
    chk("t6_rst_out", int'(out_o), 0);
    chk("t6_rst_done", int'(done_o), 0);
    chk("t6_rst_pending", int'(cfg.pending), 0);
    chk("t6_rst_valid", int'(out_valid_o), 0);
    cycle();
    rst_i = 1'b0;
    commit();
    repeat (3) cycle();
    chk("t6_shadow_valid", int'(out_valid_o), 1);
    chk("t6_shadow_out", int'(out_o), 0);
    cycle();
    chk("t6_psc_cleared", int'(out_valid_o), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
